// File: rtl/car_pkg.sv
// rtl/car_pkg.sv - shared mode and route encodings for the drive controller and motor block
package car_pkg;

  typedef enum logic [4:0] {
    IDLE         = 5'd0,
    START        = 5'd1,
    COUNT        = 5'd2,
    STRAIGHT     = 5'd3,
    CHOOSE       = 5'd4,
    LEFT         = 5'd5,
    RIGHT        = 5'd6,
    BACK         = 5'd7,
    LITTLE_LEFT  = 5'd8,
    LITTLE_RIGHT = 5'd9,
    STOP         = 5'd30,
    ERROR        = 5'd31
  } mode_e;

  typedef enum logic [1:0] {
    ROUTE_STRAIGHT = 2'b00,
    ROUTE_LEFT     = 2'b01,
    ROUTE_RIGHT    = 2'b10,
    ROUTE_BACK     = 2'b11
  } route_e;

  function automatic mode_e route_to_mode(input route_e code);
    mode_e m;
    case (code)
      ROUTE_LEFT:  m = LEFT;
      ROUTE_RIGHT: m = RIGHT;
      ROUTE_BACK:  m = BACK;
      default:     m = STRAIGHT;
    endcase
    return m;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/track_controller_if.sv
// rtl/track_controller_if.sv - sensor/start/route inputs and mode outputs of the drive controller
interface track_controller_if #(
  parameter int ROUTE_LEN = 8
);
  localparam int STEP_W = $clog2(ROUTE_LEN + 1);

  logic                   start;
  logic [2:0]             sensor;
  logic [2*ROUTE_LEN-1:0] route;
  logic [4:0]             mode;
  logic [4:0]             lastMode;
  logic [STEP_W-1:0]      step_idx;
  logic                   done;
  logic                   err;

  modport master (
    output start, sensor, route,
    input  mode, lastMode, step_idx, done, err
  );

  modport slave (
    input  start, sensor, route,
    output mode, lastMode, step_idx, done, err
  );

endinterface

// File: rtl/sensor_debounce.sv
// rtl/sensor_debounce.sv - accepts a raw vector once it has been stable for DEBOUNCE samples
module sensor_debounce #(
  parameter int WIDTH    = 3,
  parameter int DEBOUNCE = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] filt
);
  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] CNT_SAT = CW'(DEBOUNCE);

  logic [WIDTH-1:0] cand_q, cand_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] filt_q, filt_d;

  // cnt is the length of the current run of identical samples, saturating at DEBOUNCE
  always_comb begin
    cand_d = raw;
    filt_d = filt_q;
    if (raw == cand_q) begin
      cnt_d = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CW'(1);
    end else begin
      cnt_d = CW'(1);
    end
    if (cnt_d == CNT_SAT) begin
      filt_d = raw;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cand_q <= '0;
      cnt_q  <= '0;
      filt_q <= '0;
    end else begin
      cand_q <= cand_d;
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

  assign filt = filt_q;

endmodule

// File: rtl/track_controller.sv
// rtl/track_controller.sv - countdown, line following, route-driven turns and line-loss sequencing
module track_controller
  import car_pkg::*;
#(
  parameter int CLK_HZ          = 100_000_000,
  parameter int DEBOUNCE        = 1_000,
  parameter int COUNT_CYCLES    = 300_000_000,
  parameter int CHOOSE_CYCLES   = 20_000_000,
  parameter int TURN_MIN_CYCLES = 30_000_000,
  parameter int LOST_CYCLES     = 200_000_000,
  parameter int ROUTE_LEN       = 8
) (
  input logic               clk,
  input logic               rst,
  track_controller_if.slave bus
);
  localparam int STEP_W = $clog2(ROUTE_LEN + 1);
  localparam int T_MAX  = max_int(max_int(COUNT_CYCLES, CHOOSE_CYCLES), LOST_CYCLES);
  localparam int TW     = $clog2(T_MAX + 1);
  localparam int LW     = $clog2(LOST_CYCLES + 1);

  localparam logic [TW-1:0]     T_SAT       = TW'(T_MAX);
  localparam logic [TW-1:0]     COUNT_LAST  = TW'(COUNT_CYCLES - 1);
  localparam logic [TW-1:0]     CHOOSE_LAST = TW'(CHOOSE_CYCLES - 1);
  localparam logic [TW-1:0]     TURN_MIN    = TW'(TURN_MIN_CYCLES);
  localparam logic [TW-1:0]     TURN_LOST   = TW'(LOST_CYCLES);
  localparam logic [LW-1:0]     LOST_LIM    = LW'(LOST_CYCLES);
  localparam logic [STEP_W-1:0] ROUTE_END   = STEP_W'(ROUTE_LEN);

  if (CLK_HZ < 1 || DEBOUNCE < 1 || COUNT_CYCLES < 1 || CHOOSE_CYCLES < 1 ||
      TURN_MIN_CYCLES < 1 || LOST_CYCLES <= TURN_MIN_CYCLES || ROUTE_LEN < 1) begin : g_param_check
    $error("track_controller: illegal parameter set");
  end

  logic [2:0] s;

  sensor_debounce #(
    .WIDTH    (3),
    .DEBOUNCE (DEBOUNCE)
  ) u_debounce (
    .clk  (clk),
    .rst  (rst),
    .raw  (bus.sensor),
    .filt (s)
  );

  mode_e             mode_q, mode_d;
  mode_e             last_q, last_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [TW-1:0]     timer_q, timer_d, timer_inc;
  logic [LW-1:0]     lost_q, lost_d, lost_inc;
  logic              armed_q, armed_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  route_e            route_code;

  always_comb begin
    route_code = ROUTE_STRAIGHT;
    for (int k = 0; k < ROUTE_LEN; k++) begin
      if (step_q == STEP_W'(k)) begin
        route_code = route_e'(bus.route[2*k +: 2]);
      end
    end
  end

  always_comb begin
    mode_d    = mode_q;
    last_d    = last_q;
    step_d    = step_q;
    timer_d   = timer_q;
    lost_d    = '0;
    armed_d   = armed_q;
    timer_inc = (timer_q == T_SAT) ? timer_q : timer_q + TW'(1);
    lost_inc  = (lost_q == LOST_LIM) ? lost_q : lost_q + LW'(1);

    case (mode_q)
      IDLE: begin
        if (bus.start) mode_d = START;
      end
      START: begin
        mode_d  = COUNT;
        timer_d = '0;
      end
      COUNT: begin
        if (timer_q == COUNT_LAST) begin
          mode_d  = STRAIGHT;
          timer_d = '0;
        end else begin
          timer_d = timer_inc;
        end
      end
      STRAIGHT, LITTLE_LEFT, LITTLE_RIGHT: begin
        timer_d = '0;
        lost_d  = (s == 3'b000) ? lost_inc : '0;
        if (s != 3'b111) armed_d = 1'b1;
        case (s)
          3'b010:         mode_d = STRAIGHT;
          3'b100, 3'b110: mode_d = LITTLE_LEFT;
          3'b001, 3'b011: mode_d = LITTLE_RIGHT;
          3'b111: begin
            // armed keeps one long crossing from being counted twice
            if (armed_q) begin
              mode_d  = CHOOSE;
              armed_d = 1'b0;
            end
          end
          3'b000: begin
            if (lost_inc == LOST_LIM) mode_d = ERROR;
          end
          default: ;
        endcase
      end
      CHOOSE: begin
        if (timer_q == CHOOSE_LAST) begin
          timer_d = '0;
          if (step_q == ROUTE_END) begin
            mode_d = STOP;
          end else begin
            mode_d = route_to_mode(route_code);
            step_d = step_q + STEP_W'(1);
          end
        end else begin
          timer_d = timer_inc;
        end
      end
      LEFT, RIGHT, BACK: begin
        timer_d = timer_inc;
        // the middle sensor is ignored until the blind turn time has passed
        if (timer_q >= TURN_MIN && s[1]) begin
          mode_d  = STRAIGHT;
          timer_d = '0;
        end else if (timer_inc == TURN_LOST) begin
          mode_d = ERROR;
        end
      end
      STOP, ERROR: begin
        if (bus.start) begin
          mode_d  = IDLE;
          step_d  = '0;
          timer_d = '0;
          armed_d = 1'b1;
        end
      end
      default: begin
        mode_d = ERROR;
      end
    endcase

    if (mode_d != mode_q) last_d = mode_q;
    done_d = (mode_d == STOP);
    err_d  = (mode_d == ERROR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q  <= IDLE;
      last_q  <= IDLE;
      step_q  <= '0;
      timer_q <= '0;
      lost_q  <= '0;
      armed_q <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      last_q  <= last_d;
      step_q  <= step_d;
      timer_q <= timer_d;
      lost_q  <= lost_d;
      armed_q <= armed_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.mode     = mode_q;
  assign bus.lastMode = last_q;
  assign bus.step_idx = step_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_track_controller.sv
// tb/tb_track_controller.sv - directed plus randomized bench for track_controller against a behavioural model
module tb_track_controller;

  localparam int DEB  = 2;
  localparam int CNT  = 5;
  localparam int CHS  = 4;
  localparam int TMIN = 3;
  localparam int LOST = 8;
  localparam int RL   = 2;
  localparam logic [2*RL-1:0] ROUTE_PLAN = 4'b1001;

  localparam int M_IDLE = 0, M_START = 1, M_COUNT = 2, M_STRAIGHT = 3, M_CHOOSE = 4;
  localparam int M_LEFT = 5, M_RIGHT = 6, M_BACK = 7, M_LL = 8, M_LR = 9;
  localparam int M_STOP = 30, M_ERROR = 31;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  track_controller_if #(.ROUTE_LEN(RL)) bus ();

  track_controller #(
    .CLK_HZ          (100_000_000),
    .DEBOUNCE        (DEB),
    .COUNT_CYCLES    (CNT),
    .CHOOSE_CYCLES   (CHS),
    .TURN_MIN_CYCLES (TMIN),
    .LOST_CYCLES     (LOST),
    .ROUTE_LEN       (RL)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // behavioural model: time-in-mode, run lengths and a raw-sample history
  int         m_mode, m_last, m_step, m_age, m_lost, nm, code;
  bit         m_armed, arm_old, same;
  logic [2:0] m_s;
  logic [2:0] hist[$];

  always @(posedge clk) begin
    if (rst) begin
      m_mode = M_IDLE; m_last = M_IDLE; m_step = 0; m_age = 1; m_lost = 0;
      m_armed = 1'b1; m_s = 3'b000; hist.delete();
    end else begin
      nm = m_mode;
      arm_old = m_armed;
      if (!(m_mode == M_STRAIGHT || m_mode == M_LL || m_mode == M_LR)) m_lost = 0;
      case (m_mode)
        M_IDLE:  if (bus.start) nm = M_START;
        M_START: nm = M_COUNT;
        M_COUNT: if (m_age == CNT) nm = M_STRAIGHT;
        M_STRAIGHT, M_LL, M_LR: begin
          m_lost = (m_s == 3'b000) ? m_lost + 1 : 0;
          if (m_s != 3'b111) m_armed = 1'b1;
          case (m_s)
            3'b010:         nm = M_STRAIGHT;
            3'b100, 3'b110: nm = M_LL;
            3'b001, 3'b011: nm = M_LR;
            3'b111: if (arm_old) begin nm = M_CHOOSE; m_armed = 1'b0; end
            3'b000: if (m_lost == LOST) nm = M_ERROR;
            default: ;
          endcase
        end
        M_CHOOSE: if (m_age == CHS) begin
          if (m_step == RL) nm = M_STOP;
          else begin
            code = (int'(bus.route) >> (2 * m_step)) & 3;
            nm = (code == 0) ? M_STRAIGHT : (code == 1) ? M_LEFT : (code == 2) ? M_RIGHT : M_BACK;
            m_step++;
          end
        end
        M_LEFT, M_RIGHT, M_BACK: begin
          if (m_age - 1 >= TMIN && m_s[1]) nm = M_STRAIGHT;
          else if (m_age == LOST) nm = M_ERROR;
        end
        M_STOP, M_ERROR: if (bus.start) begin nm = M_IDLE; m_step = 0; m_armed = 1'b1; end
        default: ;
      endcase
      if (nm != m_mode) begin m_last = m_mode; m_mode = nm; m_age = 1; end
      else m_age++;
      hist.push_back(bus.sensor);
      if (hist.size() > DEB) void'(hist.pop_front());
      if (hist.size() == DEB) begin
        same = 1'b1;
        foreach (hist[i]) if (hist[i] != hist[0]) same = 1'b0;
        if (same) m_s = hist[0];
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("model_mode", int'(bus.mode), m_mode);
      check("model_last", int'(bus.lastMode), m_last);
      check("model_step", int'(bus.step_idx), m_step);
      check("model_done", int'(bus.done), int'(m_mode == M_STOP));
      check("model_err", int'(bus.err), int'(m_mode == M_ERROR));
    end
  end

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    wait_neg(1);
    bus.start = 1'b0;
  endtask

  logic [2:0] pats[3] = '{3'b110, 3'b010, 3'b011};
  int         exps[3] = '{M_LL, M_STRAIGHT, M_LR};
  int         prev, r, p;

  initial begin
    rst = 1'b1; bus.start = 1'b0; bus.sensor = 3'b000; bus.route = ROUTE_PLAN;
    wait_neg(2);
    cmp_en = 1'b1;
    wait_neg(1);
    check("rst_mode", int'(bus.mode), M_IDLE);
    check("rst_last", int'(bus.lastMode), M_IDLE);
    check("rst_step", int'(bus.step_idx), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_err", int'(bus.err), 0);
    rst = 1'b0;
    wait_neg(2);

    // start and countdown
    bus.sensor = 3'b010;
    pulse_start();
    check("start_mode", int'(bus.mode), M_START);
    wait_neg(5);
    check("count_mode", int'(bus.mode), M_COUNT);
    wait_neg(1);
    check("count_exit", int'(bus.mode), M_STRAIGHT);
    check("count_last", int'(bus.lastMode), M_COUNT);
    wait_neg(8);

    // line following, each change two cycles after the raw change
    prev = M_STRAIGHT;
    for (int i = 0; i < 3; i++) begin
      bus.sensor = pats[i];
      wait_neg(2);
      check("follow_hold", int'(bus.mode), prev);
      wait_neg(1);
      check("follow_react", int'(bus.mode), exps[i]);
      wait_neg(7);
      prev = exps[i];
    end
    bus.sensor = 3'b010;
    wait_neg(10);

    // first intersection: left turn with a one-cycle glitch
    bus.sensor = 3'b111;
    wait_neg(3);
    check("choose1_enter", int'(bus.mode), M_CHOOSE);
    bus.sensor = 3'b000;
    wait_neg(3);
    check("choose1_hold", int'(bus.mode), M_CHOOSE);
    wait_neg(1);
    check("turn1_mode", int'(bus.mode), M_LEFT);
    check("turn1_step", int'(bus.step_idx), 1);
    check("turn1_last", int'(bus.lastMode), M_CHOOSE);
    bus.sensor = 3'b010;
    wait_neg(1);
    bus.sensor = 3'b000;
    wait_neg(2);
    check("turn1_glitch", int'(bus.mode), M_LEFT);
    bus.sensor = 3'b010;
    wait_neg(2);
    check("turn1_wait", int'(bus.mode), M_LEFT);
    wait_neg(1);
    check("turn1_exit", int'(bus.mode), M_STRAIGHT);
    wait_neg(6);

    // second intersection with 111 held: right turn, then no re-trigger
    bus.sensor = 3'b111;
    wait_neg(7);
    check("turn2_mode", int'(bus.mode), M_RIGHT);
    check("turn2_step", int'(bus.step_idx), 2);
    wait_neg(4);
    check("turn2_exit", int'(bus.mode), M_STRAIGHT);
    wait_neg(8);
    check("armed_hold", int'(bus.mode), M_STRAIGHT);
    check("armed_step", int'(bus.step_idx), 2);
    bus.sensor = 3'b010;
    wait_neg(4);

    // third intersection completes the route
    bus.sensor = 3'b111;
    wait_neg(7);
    check("stop_mode", int'(bus.mode), M_STOP);
    check("stop_done", int'(bus.done), 1);
    check("stop_last", int'(bus.lastMode), M_CHOOSE);
    wait_neg(3);
    check("stop_hold", int'(bus.mode), M_STOP);
    bus.sensor = 3'b010;
    pulse_start();
    check("rearm_mode", int'(bus.mode), M_IDLE);
    check("rearm_step", int'(bus.step_idx), 0);
    check("rearm_done", int'(bus.done), 0);

    // line loss
    pulse_start();
    wait_neg(6);
    check("loss_straight", int'(bus.mode), M_STRAIGHT);
    wait_neg(4);
    bus.sensor = 3'b000;
    wait_neg(7);
    bus.sensor = 3'b010;
    wait_neg(12);
    check("short_loss", int'(bus.mode), M_STRAIGHT);
    check("short_loss_err", int'(bus.err), 0);
    bus.sensor = 3'b000;
    wait_neg(9);
    check("loss_pre", int'(bus.mode), M_STRAIGHT);
    wait_neg(1);
    check("loss_mode", int'(bus.mode), M_ERROR);
    check("loss_err", int'(bus.err), 1);
    check("loss_last", int'(bus.lastMode), M_STRAIGHT);
    wait_neg(2);
    check("loss_hold", int'(bus.mode), M_ERROR);
    bus.sensor = 3'b010;
    pulse_start();
    check("loss_rearm", int'(bus.mode), M_IDLE);

    // reset in the middle of a right turn, start held during reset
    pulse_start();
    wait_neg(6);
    wait_neg(3);
    bus.sensor = 3'b111;
    wait_neg(7);
    check("rt_left", int'(bus.mode), M_LEFT);
    bus.sensor = 3'b010;
    wait_neg(8);
    check("rt_back", int'(bus.mode), M_STRAIGHT);
    bus.sensor = 3'b111;
    wait_neg(7);
    check("rt_right", int'(bus.mode), M_RIGHT);
    wait_neg(1);
    rst = 1'b1;
    bus.start = 1'b1;
    wait_neg(1);
    check("rt_rst_mode", int'(bus.mode), M_IDLE);
    check("rt_rst_last", int'(bus.lastMode), M_IDLE);
    check("rt_rst_step", int'(bus.step_idx), 0);
    wait_neg(1);
    rst = 1'b0;
    bus.start = 1'b0;
    wait_neg(1);
    check("rt_start_ignored", int'(bus.mode), M_IDLE);

    // randomized traffic
    bus.sensor = 3'b010;
    for (int it = 0; it < 400; it++) begin
      r = $urandom_range(0, 99);
      if (r < 3) begin
        rst = 1'b1;
        wait_neg(1);
        rst = 1'b0;
        bus.route = (2*RL)'($urandom);
      end else if (r < 15) begin
        pulse_start();
      end else begin
        p = $urandom_range(0, 9);
        if (p < 4)       bus.sensor = 3'b010;
        else if (p == 4) bus.sensor = 3'b111;
        else if (p == 5) bus.sensor = 3'b000;
        else             bus.sensor = 3'($urandom_range(0, 7));
        wait_neg($urandom_range(1, 14));
      end
    end

    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/track_controller.md
# track_controller

Sequencing controller for the car's two-motor drive. Takes the three line-sensor inputs, a start pulse and a fixed route plan, and produces the registered `mode` / `lastMode` pair that drives the motor block. It covers countdown, line following with small corrections, intersection handling per route step, turns, route completion and line-loss error. It sits between the sensor/button front end and the motor driver, on the 100 MHz system clock.

## Interface
- `CLK_HZ`, 100_000_000: clock frequency, documentation only.
- `DEBOUNCE`, 1_000 (≥1): cycles a raw sensor pattern must be stable before it is used.
- `COUNT_CYCLES`, 300_000_000 (≥1): countdown length.
- `CHOOSE_CYCLES`, 20_000_000 (≥1): forward drive through an intersection.
- `TURN_MIN_CYCLES`, 30_000_000 (≥1): blind turn time before the middle sensor is honoured.
- `LOST_CYCLES`, 200_000_000 (>TURN_MIN_CYCLES): line-loss / turn timeout.
- `ROUTE_LEN`, 8 (≥1): number of intersections in the route.
- `clk` in 1: system clock. All logic is on its rising edge.
- `rst` in 1: synchronous reset, active-high.
- `start` in 1: start/re-arm pulse.
- `sensor` in 3: raw line sensors {L,M,R}, 1 = on line.
- `route` in 2*ROUTE_LEN: per-step action, step k at bits [2k+1:2k]. 00 straight, 01 left, 10 right, 11 back.
- `mode` out 5: current motor mode.
- `lastMode` out 5: previous distinct mode.
- `step_idx` out $clog2(ROUTE_LEN+1): intersections consumed.
- `done` out 1: high while mode = STOP.
- `err` out 1: high while mode = ERROR.

## Operation
- Reset values: mode = IDLE, lastMode = IDLE, step_idx = 0, done = 0, err = 0, filtered sensor = 000, all counters 0, armed = 1.
- Filtered sensor `s` takes the raw value once the raw value has been equal to one new pattern for DEBOUNCE consecutive cycles.
- IDLE: `start` → START.
- START: one cycle, then → COUNT with the counter loaded.
- COUNT: lasts exactly COUNT_CYCLES cycles, then → STRAIGHT.
- STRAIGHT / LITTLE_LEFT / LITTLE_RIGHT, based on `s`:
  - 010 → STRAIGHT.
  - 100 or 110 → LITTLE_LEFT.
  - 001 or 011 → LITTLE_RIGHT.
  - 111 with armed = 1 → CHOOSE, and armed is cleared.
  - 111 with armed = 0, or 101 → hold the current mode.
  - 000 → hold the current mode and increment the lost counter. When the lost counter reaches LOST_CYCLES → ERROR.
  - Any `s` ≠ 000 clears the lost counter. Any `s` ≠ 111 sets armed.
- CHOOSE: drives forward for CHOOSE_CYCLES cycles, then:
  - If step_idx = ROUTE_LEN → STOP.
  - Otherwise the route code maps 00 → STRAIGHT, 01 → LEFT, 10 → RIGHT, 11 → BACK, and step_idx increments.
- LEFT / RIGHT / BACK:
  - The turn counter starts at 0 on entry.
  - Once the counter is ≥ TURN_MIN_CYCLES and M = 1 → STRAIGHT.
  - If the counter reaches LOST_CYCLES → ERROR.
- STOP / ERROR: hold. `start` → IDLE, with step_idx cleared, counters cleared and armed = 1.
- `start` in any other state is ignored.
- lastMode updates to the old value of `mode` on every cycle where `mode` changes. Otherwise it holds.
- Counters saturate and never wrap.
- `rst` in any state wins over every other input; all outputs take their reset values on the next edge.

## Timing
- All outputs are registered. There is no combinational path from any input to any output.
- Raw `sensor` stable from edge t ⇒ `s` valid after edge t+DEBOUNCE−1 ⇒ `mode` reacts after edge t+DEBOUNCE.
- `start` sampled at edge t ⇒ mode = START after t. Mode = COUNT after t+1. Mode = STRAIGHT after t+1+COUNT_CYCLES.
- CHOOSE is visible for exactly CHOOSE_CYCLES cycles. step_idx and the new mode update on the same edge.
- done and err are registered together with `mode`, so they match `mode` in the same cycle.
- If `rst` and `start` are high on the same edge, reset wins.

## Structure
- Package `car_pkg`:
  - Mode constants: IDLE 0, START 1, COUNT 2, STRAIGHT 3, CHOOSE 4, LEFT 5, RIGHT 6, BACK 7, LITTLE_LEFT 8, LITTLE_RIGHT 9, STOP 30, ERROR 31.
  - Route codes ROUTE_STRAIGHT/LEFT/RIGHT/BACK.
  - The motor driver imports the same package.
- Sub-module `sensor_debounce`, instantiated once on the 3-bit vector. It holds the candidate register, stability counter and filtered output.
- The top level contains the FSM, shared timer, lost counter, step counter and the lastMode register.

## Test plan
Bench parameters: DEBOUNCE=2, COUNT_CYCLES=5, CHOOSE_CYCLES=4, TURN_MIN_CYCLES=3, LOST_CYCLES=8, ROUTE_LEN=2, route = {10,01}.

- Start and countdown: `start` pulse at edge 0 → mode sequence START (1 cycle), COUNT (5 cycles), STRAIGHT. lastMode = COUNT after entering STRAIGHT.
- Line following: sensor 010→110→010→011 with each pattern held 10 cycles → modes STRAIGHT, LITTLE_LEFT, STRAIGHT, LITTLE_RIGHT. Each change appears 2 cycles after the raw change.
- First intersection, left turn: sensor 111 → CHOOSE for 4 cycles → LEFT, step_idx=1. Sensor 000 for 3 cycles then 010 → STRAIGHT. A one-cycle 010 glitch during the first 3 turn cycles is ignored.
- Armed and completion: 111 held through and after CHOOSE → no second CHOOSE until `s` leaves 111. Second intersection → RIGHT, step_idx=2. Third intersection → STOP with done=1. `start` → IDLE, step_idx=0.
- Line loss: in STRAIGHT, sensor 000 for 12 cycles → ERROR 8 cycles after `s` = 000, err=1. A 000 run shorter than 8 cycles followed by 010 keeps STRAIGHT.
- Reset mid-turn: `rst` high during RIGHT → next edge gives mode = IDLE, lastMode = IDLE, step_idx=0. `start` while `rst` is high is ignored.
